// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the duty-cycle clock generator.
// Config fields are carried at CNT_W_DEFAULT bits; narrower instances zero-extend into them.
package clkgen_pkg;

    localparam int CNT_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    typedef struct packed {
        logic [CNT_W_DEFAULT-1:0] period;
        logic [CNT_W_DEFAULT-1:0] high;
    } clk_cfg_t;

    // A usable shape needs at least one low and one high cycle.
    function automatic logic cfg_is_valid(input clk_cfg_t cfg);
        logic ok;
        ok = (cfg.period >= CNT_W_DEFAULT'(2))
          && (cfg.high   >= CNT_W_DEFAULT'(1))
          && (cfg.high   <  cfg.period);
        return ok;
    endfunction

endpackage

// File: rtl/clkgen_cfg_shadow.sv
// Config port: valid/ready handshake, request validation, error pulse and the
// one-deep shadow register that the generator FSM drains with a load strobe.
module clkgen_cfg_shadow
    import clkgen_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    input  logic             load,
    output logic             shadow_full,
    output clk_cfg_t         shadow_cfg
);

    clk_cfg_t req_s;
    clk_cfg_t shadow_r;
    clk_cfg_t shadow_s;
    logic     full_r;
    logic     full_s;
    logic     ready_r;
    logic     err_r;
    logic     err_s;
    logic     accept_s;
    logic     req_ok_s;

    // Accept/validate requests and track shadow occupancy; load only happens while full,
    // so it can never coincide with an accept.
    always_comb begin
        req_s.period = CNT_W_DEFAULT'(cfg_period);
        req_s.high   = CNT_W_DEFAULT'(cfg_high);
        req_ok_s     = cfg_is_valid(req_s);
        accept_s     = cfg_valid & ready_r;
        full_s       = full_r;
        shadow_s     = shadow_r;
        err_s        = 1'b0;
        if (accept_s) begin
            if (req_ok_s) begin
                full_s   = 1'b1;
                shadow_s = req_s;
            end else begin
                err_s    = 1'b1;
            end
        end else if (load) begin
            full_s = 1'b0;
        end else begin
            full_s = full_r;
        end
    end

    // Shadow state and registered handshake outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            full_r   <= 1'b0;
            shadow_r <= '0;
            ready_r  <= 1'b1;
            err_r    <= 1'b0;
        end else begin
            full_r   <= full_s;
            shadow_r <= shadow_s;
            ready_r  <= ~full_s;
            err_r    <= err_s;
        end
    end

    assign cfg_ready   = ready_r;
    assign cfg_err     = err_r;
    assign shadow_full = full_r;
    assign shadow_cfg  = shadow_r;

endmodule

// File: rtl/clkgen_duty_ctrl.sv
// Runtime duty-cycle clock generator: low phase then high phase per period,
// config changes and stop requests only take effect on period boundaries.
module clkgen_duty_ctrl
    import clkgen_pkg::*;
#(
    parameter int CNT_W      = CNT_W_DEFAULT,
    parameter int DEF_PERIOD = 10,
    parameter int DEF_HIGH   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    output logic             cfg_err,
    output logic             clk_out,
    output logic             period_start,
    output logic             active
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic [CNT_W-1:0] act_period_r;
    logic [CNT_W-1:0] act_high_r;
    logic [CNT_W-1:0] act_period_s;
    logic [CNT_W-1:0] act_high_s;
    logic [CNT_W-1:0] sh_period_s;
    logic [CNT_W-1:0] sh_high_s;
    logic [CNT_W-1:0] eff_period_s;
    logic [CNT_W-1:0] eff_high_s;
    logic [CNT_W-1:0] eff_low_s;
    logic             clk_out_r;
    logic             period_start_r;
    logic             period_start_s;
    logic             active_r;
    logic             load_s;
    logic             shadow_full_s;
    clk_cfg_t         shadow_cfg_s;

    clkgen_cfg_shadow #(
        .CNT_W (CNT_W)
    ) u_cfg_shadow (
        .clock       (clock),
        .reset       (reset),
        .cfg_valid   (cfg_valid),
        .cfg_ready   (cfg_ready),
        .cfg_period  (cfg_period),
        .cfg_high    (cfg_high),
        .cfg_err     (cfg_err),
        .load        (load_s),
        .shadow_full (shadow_full_s),
        .shadow_cfg  (shadow_cfg_s)
    );

    assign sh_period_s = CNT_W'(shadow_cfg_s.period);
    assign sh_high_s   = CNT_W'(shadow_cfg_s.high);

    // A period that starts together with a shadow load must already use the new shape.
    assign eff_period_s = shadow_full_s ? sh_period_s : act_period_r;
    assign eff_high_s   = shadow_full_s ? sh_high_s   : act_high_r;
    assign eff_low_s    = eff_period_s - eff_high_s;

    // Next-state, counter reload and shadow load decisions.
    always_comb begin
        state_s        = state_r;
        cnt_s          = cnt_r;
        period_start_s = 1'b0;
        load_s         = 1'b0;
        case (state_r)
            ST_IDLE: begin
                load_s = shadow_full_s;
                if (enable) begin
                    state_s        = ST_LOW;
                    cnt_s          = eff_low_s - ONE;
                    period_start_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            end
            ST_LOW: begin
                if (cnt_r == '0) begin
                    state_s = ST_HIGH;
                    cnt_s   = act_high_r - ONE;
                end else begin
                    cnt_s   = cnt_r - ONE;
                end
            end
            ST_HIGH: begin
                if (cnt_r == '0) begin
                    load_s = shadow_full_s;
                    if (enable) begin
                        state_s        = ST_LOW;
                        cnt_s          = eff_low_s - ONE;
                        period_start_s = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = '0;
                    end
                end else begin
                    cnt_s = cnt_r - ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
            end
        endcase
        if (load_s) begin
            act_period_s = eff_period_s;
            act_high_s   = eff_high_s;
        end else begin
            act_period_s = act_period_r;
            act_high_s   = act_high_r;
        end
    end

    // State, counter, active config and registered outputs decoded from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            cnt_r          <= '0;
            act_period_r   <= CNT_W'(DEF_PERIOD);
            act_high_r     <= CNT_W'(DEF_HIGH);
            clk_out_r      <= 1'b0;
            period_start_r <= 1'b0;
            active_r       <= 1'b0;
        end else begin
            state_r        <= state_s;
            cnt_r          <= cnt_s;
            act_period_r   <= act_period_s;
            act_high_r     <= act_high_s;
            clk_out_r      <= (state_s == ST_HIGH);
            period_start_r <= period_start_s;
            active_r       <= (state_s != ST_IDLE);
        end
    end

    assign clk_out      = clk_out_r;
    assign period_start = period_start_r;
    assign active       = active_r;

endmodule

// File: doc/clkgen_duty_ctrl.md
Name: clkgen_duty_ctrl

Overview:
Synthesizable runtime controller for a duty-cycle clock. It generates a divided clock with a programmable period and high time, counted in cycles of the fast reference clock. New period/high settings arrive over a valid/ready config port and take effect only on period boundaries, so clk_out never glitches. Start and stop are clean: a period always completes before the output idles low.

Parameters:
CNT_W, 16, width of the period and high-time counters and config fields.
DEF_PERIOD, 10, period in reference cycles loaded at reset (must be ≥2).
DEF_HIGH, 8, high-phase cycles loaded at reset (80% duty; 1..DEF_PERIOD-1).

Ports:
clock  in  1  reference clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
enable  in  1  level; 1 = run the output clock, 0 = stop at the next period end.
cfg_valid  in  1  config request valid.
cfg_ready  out  1  config slot free; a transfer occurs when cfg_valid & cfg_ready.
cfg_period  in  CNT_W  requested period in reference cycles.
cfg_high  in  CNT_W  requested high-phase cycles.
cfg_err  out  1  one-cycle pulse: the accepted request was invalid and was discarded.
clk_out  out  1  generated clock, registered.
period_start  out  1  one-cycle pulse on the first cycle of each period.
active  out  1  1 while the state is not IDLE.

Behaviour:
- Reset (synchronous, overrides everything):
  - state=IDLE; clk_out=0, period_start=0, cfg_err=0, active=0.
  - Active config = DEF_PERIOD/DEF_HIGH; shadow config empty; cfg_ready=1.
  - Reset mid-period: clk_out=0 on the next cycle, with no completion of the period.
- Period shape: each period is low phase first, then high phase.
  - L = period-high cycles with clk_out=0, then H = high cycles with clk_out=1.
  - Exact cycle counts; no rounding.
- States:
  - IDLE: clk_out=0. If enable=1 in cycle t, state=LOW at t+1 with period_start=1 at t+1.
  - LOW: counter runs L cycles, then HIGH.
  - HIGH: counter runs H cycles. The last HIGH cycle is the boundary.
    - At the boundary with enable=1: go to LOW and pulse period_start.
    - At the boundary with enable=0: go to IDLE, so clk_out=0 and active=0 on the next cycle.
  - enable is sampled only in IDLE and at the boundary. Deasserting it mid-period never truncates a phase.
- Config validity: valid iff period≥2 and 1≤high≤period-1.
  - An invalid request is still handshaken (consumed).
  - cfg_err=1 the cycle after acceptance; the shadow and active config are unchanged.
- Config transfer:
  - One-deep shadow register.
  - cfg_ready=1 when the shadow is empty; it drops the cycle after a valid request is accepted into the shadow.
- Config apply:
  - In IDLE, the shadow loads into the active config on the next cycle.
  - While running, the shadow loads only at the boundary. The new period starts with the new L/H, and the shadow empties (cfg_ready=1 on the next cycle).
- Simultaneous events:
  - A request accepted in the same cycle as a boundary is not applied at that boundary; it applies at the following one.
  - enable rising in the same IDLE cycle as a shadow load: the first period uses the new config.
- Counter: CNT_W bits, down-counter loaded with L-1 / H-1. No wrap; terminal count at 0.
- Arithmetic: L = period-high, computed in CNT_W bits. Validation guarantees no underflow.

Decomposition:
- Package clkgen_pkg:
  - state enum (IDLE, LOW, HIGH).
  - CNT_W default constant.
  - typedef clk_cfg_t struct {period, high}.
  - function cfg_is_valid(clk_cfg_t).
- One sub-module, clkgen_cfg_shadow: owns the valid/ready handshake, validation, the cfg_err pulse and the shadow register. It exposes shadow_full, shadow_cfg and a load strobe from the FSM.
- FSM, counter and clk_out register live in clkgen_duty_ctrl.

Test Plan:
- Defaults: reset, then enable=1.
  - clk_out repeats 2 cycles 0 / 8 cycles 1.
  - period_start every 10 cycles, on the first low cycle.
  - First period_start 1 cycle after enable.
- Mid-period reconfig: while running defaults, send period=4, high=1 during a LOW phase.
  - cfg_ready drops.
  - The current 2/8 period completes, then 3 low / 1 high repeats.
  - cfg_ready returns the cycle after the boundary.
- Invalid config: send period=5, high=0, then period=1, high=1.
  - cfg_err pulses once for each request.
  - Waveform stays 2/8; cfg_ready stays 1.
- Backpressure: send two valid configs back-to-back (period=6/high=3, then period=8/high=4).
  - The second stalls with cfg_ready=0 until the boundary.
  - Periods are then 6(3/3) followed by 8(4/4).
- Stop: drop enable during the 3rd high cycle.
  - The remaining 5 high cycles complete.
  - clk_out=0 and active=0 on the cycle after the boundary; no further period_start.
- Reset mid-high: assert reset during HIGH with a pending shadow config.
  - clk_out=0 and active=0 next cycle; shadow discarded.
  - Re-enable produces 2/8 again.
